// File: rtl/capture_reader.sv
// Capture RAM readout engine: streams a window of samples from a synchronous-read
// RAM into a valid/ready output through a 2-entry FIFO.
module capture_reader #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [ADDR_W:0]   CntOne  = 1;
    localparam logic [ADDR_W-1:0] AddrOne = 1;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   issued_q;
    logic [ADDR_W:0]   sent_q;
    logic              pending_q;
    logic [DATA_W-1:0] fifo_mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        fifo_cnt_q;

    logic              in_run;
    logic              pop;
    logic              issue;
    logic              last_xfer;
    logic [2:0]        occupancy;

    // Read issue, stream outputs and status; everything is forced low while rst is high.
    always_comb begin
        in_run      = (state_q == StRun) && !rst;
        out_valid   = in_run && (fifo_cnt_q != 2'd0);
        pop         = out_valid && out_ready;
        // Credit the entry leaving this cycle so a full-rate stream never bubbles;
        // FIFO entries plus in-flight reads still never exceed two.
        occupancy   = 3'(fifo_cnt_q) + 3'(pending_q) - 3'(pop);
        issue       = in_run && !abort && (issued_q < len_q) && (occupancy < 3'd2);
        ram_rd_en   = issue;
        ram_rd_addr = rst ? '0 : addr_q;
        out_data    = out_valid ? fifo_mem_q[rd_ptr_q] : '0;
        out_last    = out_valid && ((sent_q + CntOne) == len_q);
        last_xfer   = pop && out_last;
        busy        = in_run;
        done        = (state_q == StDone) && !rst;
    end

    // Readout FSM with address/count tracking and the output FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            pending_q  <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= '0;
        end else begin
            pending_q <= issue;
            unique case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        addr_q     <= start_addr;
                        len_q      <= length;
                        issued_q   <= '0;
                        sent_q     <= '0;
                        wr_ptr_q   <= 1'b0;
                        rd_ptr_q   <= 1'b0;
                        fifo_cnt_q <= '0;
                        state_q    <= (length == '0) ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (abort) begin
                        // Drop buffered samples; pending_q is already cleared since issue is low.
                        fifo_cnt_q <= '0;
                        state_q    <= StIdle;
                    end else begin
                        if (issue) begin
                            addr_q   <= addr_q + AddrOne;
                            issued_q <= issued_q + CntOne;
                        end
                        if (pending_q) begin
                            fifo_mem_q[wr_ptr_q] <= ram_rd_data;
                            wr_ptr_q             <= ~wr_ptr_q;
                        end
                        if (pop) begin
                            rd_ptr_q <= ~rd_ptr_q;
                            sent_q   <= sent_q + CntOne;
                        end
                        fifo_cnt_q <= fifo_cnt_q + 2'(pending_q) - 2'(pop);
                        if (last_xfer) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
